// File: rtl/rr_arbiter_if.sv
// rtl/rr_arbiter_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_arbiter_if #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic               flush;
  logic               out_ready;
  logic               out_valid;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] base_ptr;

  // Arbiter side: consumes requests, produces grants
  modport master (
    input  req,
    input  flush,
    input  out_ready,
    output out_valid,
    output grant_onehot,
    output grant_idx,
    output base_ptr
  );

  // Requester/consumer side
  modport slave (
    output req,
    output flush,
    output out_ready,
    input  out_valid,
    input  grant_onehot,
    input  grant_idx,
    input  base_ptr
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin / fixed-priority arbiter with grant hold under backpressure
module rr_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int MODE    = 0,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic         clock,
  input  logic         reset,
  rr_arbiter_if.master bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_base;
  logic [NUM_REQ-1:0] r_held;

  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] w_base_nxt;
  logic [NUM_REQ-1:0] w_held_nxt;
  logic [NUM_REQ-1:0] w_upper;
  logic [NUM_REQ-1:0] w_scan;
  logic [NUM_REQ-1:0] w_sel;
  logic               w_valid;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;

  // Circular find-first-one: keep requests at/above the base; if none, wrap to the lowest request.
  // base is one-hot, so (base - 1) is exactly the mask of bits below it.
  always_comb begin
    w_upper = bus.req & ~(r_base - ONE);
    w_scan  = (|w_upper) ? w_upper : bus.req;
    w_sel   = w_scan & (~w_scan + ONE);
  end

  // Next-state and outputs; flush and reset both force an empty grant
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_held_nxt  = r_held;
    w_valid     = 1'b0;
    w_grant     = '0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if ((|bus.req) && !bus.flush) begin
            w_valid = 1'b1;
            w_grant = w_sel;
            if (bus.out_ready) begin
              if (MODE == 0) w_base_nxt = {w_sel[NUM_REQ-2:0], w_sel[NUM_REQ-1]};
            end else begin
              w_held_nxt  = w_sel;
              w_state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.flush) begin
            w_held_nxt  = '0;
            w_state_nxt = IDLE;
          end else begin
            w_valid = 1'b1;
            w_grant = r_held;
            if (bus.out_ready) begin
              if (MODE == 0) w_base_nxt = {r_held[NUM_REQ-2:0], r_held[NUM_REQ-1]};
              w_held_nxt  = '0;
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Binary encode of the one-hot grant
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_idx = w_idx | IDX_W'(i);
    end
  end

  // State, priority base and held grant registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_base  <= ONE;
      r_held  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_held  <= w_held_nxt;
    end
  end

  assign bus.out_valid    = w_valid;
  assign bus.grant_onehot = w_grant;
  assign bus.grant_idx    = w_idx;
  assign bus.base_ptr     = r_base;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - scoreboard bench for rr_arbiter (round-robin N=4, fixed-priority N=6)
module tb_rr_arbiter;

  typedef struct {
    logic       v;
    logic [7:0] g;
    logic [5:0] i;
    logic [7:0] b;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst4 = 1'b1;
  logic rst6 = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q4[$];
  exp_t q6[$];

  always #5 clk = ~clk;

  rr_arbiter_if #(.NUM_REQ(4)) if4();
  rr_arbiter_if #(.NUM_REQ(6)) if6();

  rr_arbiter #(.NUM_REQ(4), .MODE(0)) u_rr (.clock(clk), .reset(rst4), .bus(if4.master));
  rr_arbiter #(.NUM_REQ(6), .MODE(1)) u_fp (.clock(clk), .reset(rst6), .bus(if6.master));

  task automatic chk(input string n, input string f, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", n, f, act, exp);
    end
  endtask

  task automatic step4(input logic r, input logic [3:0] req, input logic fl, input logic rdy,
                       input logic v, input logic [3:0] g, input logic [1:0] i, input logic [3:0] b,
                       input string n);
    exp_t e;
    @(posedge clk);
    #1;
    rst4 = r; if4.req = req; if4.flush = fl; if4.out_ready = rdy;
    e.v = v; e.g = 8'(g); e.i = 6'(i); e.b = 8'(b); e.name = n;
    q4.push_back(e);
  endtask

  task automatic step6(input logic r, input logic [5:0] req, input logic rdy,
                       input logic v, input logic [5:0] g, input logic [2:0] i, input logic [5:0] b,
                       input string n);
    exp_t e;
    @(posedge clk);
    #1;
    rst6 = r; if6.req = req; if6.flush = 1'b0; if6.out_ready = rdy;
    e.v = v; e.g = 8'(g); e.i = 6'(i); e.b = 8'(b); e.name = n;
    q6.push_back(e);
  endtask

  // Monitor for the round-robin instance: compares every observed cycle
  always @(negedge clk) begin
    if (q4.size() > 0) begin
      exp_t e;
      e = q4.pop_front();
      chk(e.name, "valid", 8'(if4.out_valid), 8'(e.v));
      chk(e.name, "grant", 8'(if4.grant_onehot), e.g);
      chk(e.name, "idx", 8'(if4.grant_idx), 8'(e.i));
      chk(e.name, "base", 8'(if4.base_ptr), e.b);
    end
  end

  // Monitor for the fixed-priority instance
  always @(negedge clk) begin
    if (q6.size() > 0) begin
      exp_t e;
      e = q6.pop_front();
      chk(e.name, "valid", 8'(if6.out_valid), 8'(e.v));
      chk(e.name, "grant", 8'(if6.grant_onehot), e.g);
      chk(e.name, "idx", 8'(if6.grant_idx), 8'(e.i));
      chk(e.name, "base", 8'(if6.base_ptr), e.b);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if4.req = '0; if4.flush = 1'b0; if4.out_ready = 1'b0;
    if6.req = '0; if6.flush = 1'b0; if6.out_ready = 1'b0;
    repeat (2) @(posedge clk);

    //     rst req     fl rdy  v  grant   idx  base
    step4(1, 4'b1111, 0, 1, 0, 4'b0000, 0, 4'b0001, "reset_req");
    step4(0, 4'b1010, 0, 1, 1, 4'b0010, 1, 4'b0001, "rot1");
    step4(0, 4'b1010, 0, 1, 1, 4'b1000, 3, 4'b0100, "rot2");
    step4(0, 4'b0100, 0, 1, 1, 4'b0100, 2, 4'b0001, "to_base3");
    step4(0, 4'b0011, 0, 1, 1, 4'b0001, 0, 4'b1000, "wrap");
    step4(0, 4'b0000, 0, 1, 0, 4'b0000, 0, 4'b0010, "idle");
    step4(0, 4'b1000, 0, 1, 1, 4'b1000, 3, 4'b0010, "idle_base_kept");
    step4(0, 4'b0110, 0, 0, 1, 4'b0010, 1, 4'b0001, "bp_latch");
    step4(0, 4'b0100, 0, 0, 1, 4'b0010, 1, 4'b0001, "bp_hold1");
    step4(0, 4'b0100, 0, 0, 1, 4'b0010, 1, 4'b0001, "bp_hold2");
    step4(0, 4'b0000, 0, 0, 1, 4'b0010, 1, 4'b0001, "bp_req_gone");
    step4(0, 4'b0100, 0, 1, 1, 4'b0010, 1, 4'b0001, "bp_accept");
    step4(0, 4'b0010, 0, 0, 1, 4'b0010, 1, 4'b0100, "after_bp");
    step4(0, 4'b1111, 1, 1, 0, 4'b0000, 0, 4'b0100, "flush_hold");
    step4(0, 4'b1000, 0, 1, 1, 4'b1000, 3, 4'b0100, "post_flush_idle");
    step4(0, 4'b1111, 1, 1, 0, 4'b0000, 0, 4'b0001, "flush_idle");
    step4(0, 4'b0100, 0, 1, 1, 4'b0100, 2, 4'b0001, "post_flush2");
    step4(0, 4'b0100, 0, 0, 1, 4'b0100, 2, 4'b1000, "hold_for_rst");
    step4(1, 4'b0110, 0, 0, 0, 4'b0000, 0, 4'b1000, "rst_in_hold");
    step4(0, 4'b0110, 0, 0, 1, 4'b0010, 1, 4'b0001, "after_rst");
    step4(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 4'b0001, "cleanup");

    step6(1, 6'b101010, 1, 0, 6'b000000, 0, 6'b000001, "fp_reset");
    for (int k = 0; k < 4; k++)
      step6(0, 6'b101010, 1, 1, 6'b000010, 1, 6'b000001, "fp_rep");
    step6(0, 6'b100000, 1, 1, 6'b100000, 5, 6'b000001, "fp_top");
    step6(0, 6'b101010, 1, 1, 6'b000010, 1, 6'b000001, "fp_after_top");
    step6(0, 6'b000000, 1, 0, 6'b000000, 0, 6'b000001, "fp_idle");

    repeat (3) @(posedge clk);
    checks++;
    if (q4.size() + q6.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", q4.size() + q6.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
